// File: rtl/data_memory_ctrl.sv
// Handshaked byte/half/word data memory for the MIPS load/store path with
// post-reset clear sweep, configurable read latency and a debug read port.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      address,
    input  logic [31:0]      writeData,
    output logic             resp_valid,
    output logic             resp_error,
    output logic [31:0]      readData,
    output logic             busy,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic [31:0]      dbg_data
);

    typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT, RESP} state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  clr_idx_r;
    logic [31:0]       pend_data_r;
    logic              pend_err_r;
    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              accept_s;
    logic [IDX_W-1:0]  idx_s;
    logic              oor_s;
    logic              misalign_s;
    logic              err_s;
    logic [31:0]       word_s;
    logic [31:0]       shifted_s;
    logic [31:0]       load_data_s;
    logic              we_s;
    logic [3:0]        wmask_s;
    logic [31:0]       wdata_s;
    logic [IDX_W-1:0]  widx_s;

    assign accept_s  = req_valid & req_ready;
    assign idx_s     = address[IDX_W+1:2];
    assign oor_s     = |address[31:IDX_W+2];
    assign err_s     = oor_s | misalign_s;
    assign word_s    = mem_r[idx_s];
    assign shifted_s = word_s >> {address[1:0], 3'b000};
    assign dbg_data  = mem_r[dbg_addr];

    // Alignment check and lane select / extension of the addressed word.
    always_comb begin
        misalign_s  = 1'b1;
        load_data_s = 32'd0;
        case (req_size)
            2'b00: begin
                misalign_s  = 1'b0;
                load_data_s = req_unsigned ? {24'd0, shifted_s[7:0]}
                                           : {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
            2'b01: begin
                misalign_s  = address[0];
                load_data_s = req_unsigned ? {16'd0, shifted_s[15:0]}
                                           : {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
            2'b10: begin
                misalign_s  = |address[1:0];
                load_data_s = word_s;
            end
            default: begin
                misalign_s  = 1'b1;
                load_data_s = 32'd0;
            end
        endcase
    end

    // Write port arbitration: clear sweep or a legal accepted store; reset wins.
    always_comb begin
        we_s    = 1'b0;
        wmask_s = 4'h0;
        wdata_s = 32'd0;
        widx_s  = clr_idx_r;
        if (reset) begin
            we_s = 1'b0;
        end else if (state_r == CLEAR) begin
            we_s    = 1'b1;
            wmask_s = 4'hF;
            wdata_s = 32'd0;
            widx_s  = clr_idx_r;
        end else if (accept_s && req_write && !err_s) begin
            we_s    = 1'b1;
            widx_s  = idx_s;
            wdata_s = writeData << {address[1:0], 3'b000};
            case (req_size)
                2'b00:   wmask_s = 4'b0001 << address[1:0];
                2'b01:   wmask_s = 4'b0011 << {address[1], 1'b0};
                2'b10:   wmask_s = 4'b1111;
                default: wmask_s = 4'b0000;
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Byte-lane masked memory array; not reset so contents can survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask_s[k]) begin
                    mem_r[widx_s][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            clr_idx_r   <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            readData    <= 32'd0;
            busy        <= (INIT_CLEAR != 0);
            pend_data_r <= 32'd0;
            pend_err_r  <= 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    clr_idx_r <= clr_idx_r + IDX_W'(1);
                    if (clr_idx_r == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                IDLE, RESP: begin
                    if (accept_s && !req_write && READ_LATENCY == 2) begin
                        state_r     <= RD_WAIT;
                        req_ready   <= 1'b0;
                        resp_valid  <= 1'b0;
                        resp_error  <= 1'b0;
                        readData    <= 32'd0;
                        pend_err_r  <= err_s;
                        pend_data_r <= err_s ? 32'd0 : load_data_s;
                    end else if (accept_s) begin
                        state_r    <= RESP;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_error <= err_s;
                        readData   <= (req_write || err_s) ? 32'd0 : load_data_s;
                    end else begin
                        state_r    <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        readData   <= 32'd0;
                    end
                end
                RD_WAIT: begin
                    state_r    <= RESP;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_error <= pend_err_r;
                    readData   <= pend_data_r;
                end
                default: begin
                    state_r    <= IDLE;
                    req_ready  <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    readData   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a 16-word latency-1 clearing instance and a 1024-word
// latency-2 retaining instance share one request driver selected by sel.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst1, rst2, sel;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] address, writeData;
    logic [3:0]  dbg1;
    logic [9:0]  dbg2;

    logic        rdy1, rv1, err1, busy1;
    logic        rdy2, rv2, err2, busy2;
    logic [31:0] rd1, rd2, dd1, dd2;

    logic        cur_ready, cur_rv, cur_err;
    logic [31:0] cur_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cur_ready = sel ? rdy2 : rdy1;
    assign cur_rv    = sel ? rv2  : rv1;
    assign cur_err   = sel ? err2 : err1;
    assign cur_rd    = sel ? rd2  : rd1;

    data_memory_ctrl #(.DEPTH_WORDS(16), .READ_LATENCY(1), .INIT_CLEAR(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(req_valid & ~sel), .req_ready(rdy1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .writeData(writeData), .resp_valid(rv1),
        .resp_error(err1), .readData(rd1), .busy(busy1), .dbg_addr(dbg1),
        .dbg_data(dd1));

    data_memory_ctrl #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .INIT_CLEAR(0)) dut2 (
        .clk(clk), .reset(rst2), .req_valid(req_valid & sel), .req_ready(rdy2),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .writeData(writeData), .resp_valid(rv2),
        .resp_error(err2), .readData(rd2), .busy(busy2), .dbg_addr(dbg2),
        .dbg_data(dd2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request, entered and left at a falling edge; waits are bounded.
    task automatic req(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        int n;
        req_write = w; req_size = sz; req_unsigned = u; address = a; writeData = d;
        req_valid = 1'b1;
        n = 0;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_seen", {31'd0, cur_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!cur_rv && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid_seen", {31'd0, cur_rv}, 32'd1);
        rd = cur_rd;
        er = cur_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        er;
    int          cnt, acc, ri;
    logic        a;
    logic [7:0]  rv_hist, rdy_hist;
    logic [31:0] got [3];

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        address = 32'd0; writeData = 32'd0; dbg1 = 4'd0; dbg2 = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready1", {31'd0, rdy1}, 32'd0);
        chk("rst_rv1",    {31'd0, rv1},  32'd0);
        chk("rst_busy1",  {31'd0, busy1}, 32'd1);
        chk("rst_rd1",    rd1, 32'd0);
        chk("rst_busy2",  {31'd0, busy2}, 32'd0);
        chk("rst_ready2", {31'd0, rdy2}, 32'd0);

        // Initial clear sweep of dut1
        rst1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("clear_busy_cycles", cnt, 32'd16);
        chk("clear_ready", {31'd0, rdy1}, 32'd1);

        req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, rd, er);
        chk("store_rd_zero", rd, 32'd0);
        chk("store_err", {31'd0, er}, 32'd0);
        dbg1 = 4'd5;
        #1 chk("dbg5_written", dd1, 32'hDEADBEEF);

        // Byte lanes and extension
        req(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, rd, er);
        req(1'b1, 2'b00, 1'b0, 32'hA, 32'h00000080, rd, er);
        req(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er);
        chk("word_after_byte", rd, 32'h11803344);
        req(1'b0, 2'b00, 1'b0, 32'hA, 32'd0, rd, er);
        chk("byte_signed", rd, 32'hFFFFFF80);
        req(1'b0, 2'b00, 1'b1, 32'hA, 32'd0, rd, er);
        chk("byte_unsigned", rd, 32'h00000080);

        // Half lanes
        req(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, rd, er);
        req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, rd, er);
        req(1'b0, 2'b01, 1'b1, 32'h6, 32'd0, rd, er);
        chk("half_unsigned", rd, 32'h0000BEEF);
        req(1'b0, 2'b01, 1'b0, 32'h6, 32'd0, rd, er);
        chk("half_signed", rd, 32'hFFFFBEEF);
        req(1'b0, 2'b10, 1'b0, 32'h4, 32'd0, rd, er);
        chk("word1_low_kept", rd, 32'hBEEFF00D);

        // Errors on dut1
        req(1'b0, 2'b10, 1'b0, 32'h2, 32'd0, rd, er);
        chk("misalign_err", {31'd0, er}, 32'd1);
        chk("misalign_rd", rd, 32'd0);
        req(1'b0, 2'b11, 1'b0, 32'h8, 32'd0, rd, er);
        chk("size11_err", {31'd0, er}, 32'd1);
        req(1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF, rd, er);
        chk("oor_store_err", {31'd0, er}, 32'd1);
        dbg1 = 4'd0;
        #1 chk("oor_word0_kept", dd1, 32'd0);
        req(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, rd, er);
        chk("word2_kept", rd, 32'h11803344);
        chk("legal_err", {31'd0, er}, 32'd0);

        // Clear sweep after a reset pulse
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("reclear_busy_cycles", cnt, 32'd16);
        chk("reclear_ready", {31'd0, rdy1}, 32'd1);
        dbg1 = 4'd5;
        #1 chk("dbg5_cleared", dd1, 32'd0);

        // dut2: retaining, latency 2
        @(negedge clk);
        sel = 1'b1;
        rst2 = 1'b0;
        @(negedge clk);
        chk("ready2_after_release", {31'd0, rdy2}, 32'd1);
        req(1'b1, 2'b10, 1'b0, 32'h0,  32'h55AA55AA, rd, er);
        req(1'b1, 2'b10, 1'b0, 32'h10, 32'h13579BDF, rd, er);
        req(1'b1, 2'b10, 1'b0, 32'h14, 32'h2468ACE0, rd, er);
        req(1'b1, 2'b10, 1'b0, 32'h18, 32'h0F0F0F0F, rd, er);
        req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, rd, er);
        chk("oor1024_err", {31'd0, er}, 32'd1);
        dbg2 = 10'd0;
        #1 chk("oor1024_word0_kept", dd2, 32'h55AA55AA);

        // Back-to-back loads with valid held high
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        address = 32'h10; req_valid = 1'b1;
        acc = 0; ri = 0;
        for (int i = 0; i < 8; i++) begin
            rv_hist[i]  = rv2;
            rdy_hist[i] = rdy2;
            if (rv2 && ri < 3) begin
                got[ri] = rd2;
                ri++;
            end
            a = req_valid && rdy2;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                if (acc == 3) req_valid = 1'b0;
                else address = 32'h10 + 32'(acc) * 32'd4;
            end
            @(negedge clk);
        end
        chk("b2b_resp_pattern",  {24'd0, rv_hist},  32'h54);
        chk("b2b_ready_pattern", {24'd0, rdy_hist}, 32'hD5);
        chk("b2b_resp_count", ri, 32'd3);
        chk("b2b_data0", got[0], 32'h13579BDF);
        chk("b2b_data1", got[1], 32'h2468ACE0);
        chk("b2b_data2", got[2], 32'h0F0F0F0F);

        // Reset during RD_WAIT drops the response
        req_write = 1'b0; req_size = 2'b10; address = 32'h14; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rdwait_rv", {31'd0, rv2}, 32'd0);
        chk("rdwait_ready", {31'd0, rdy2}, 32'd0);
        rst2 = 1'b1;
        @(negedge clk);
        chk("reset_drop_rv", {31'd0, rv2}, 32'd0);
        rst2 = 1'b0;
        @(negedge clk);
        chk("post_reset_rv", {31'd0, rv2}, 32'd0);
        chk("post_reset_ready", {31'd0, rdy2}, 32'd1);
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er);
        chk("retained_word4", rd, 32'h13579BDF);
        req(1'b0, 2'b00, 1'b1, 32'h3, 32'd0, rd, er);
        chk("retained_byte3", rd, 32'h00000055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
